icache_refill_unit: RTL and testbench
=====================================

# icache_refill_unit

Memory-side refill engine directly downstream of the instruction cache miss path. Accepts one `icache2mem_req_t` line request at a time (demand or prefetch), issues a single burst read on the memory bus, assembles `BEAT_W`-wide return beats into a full `Cfg.ICACHE_LINE_WIDTH` line, and returns it to the icache as a one-cycle `mem2icache_rsp_t` pulse. Supports flush-driven cancellation without violating bus handshake rules.

## Interface
- `LINE_W`, `Cfg.ICACHE_LINE_WIDTH`: refill line width in bits
- `ADDR_W`, `Cfg.PLEN`: physical address width
- `BEAT_W`, 64: bus data beat width; `LINE_W % BEAT_W == 0`; `BEATS = LINE_W/BEAT_W`, must be ≥2 and ≤256
- `clk_i` in 1: clock, all state changes on the rising edge
- `rst_ni` in 1: asynchronous, active-low reset
- `icache_req_i` in `icache2mem_req_t`: line request; `valid`, `addr`, `is_prefetch`
- `icache_rsp_o` out `mem2icache_rsp_t`: `ready` = request accepted this cycle; `valid` = line delivered this cycle; `data`; `is_prefetch`
- `flush_i` in 1: cancel any outstanding refill
- `bus_req_valid_o` out 1, `bus_req_ready_i` in 1: bus read-request handshake
- `bus_req_addr_o` out ADDR_W: line-aligned burst start address
- `bus_req_len_o` out 8: burst length, constant `BEATS-1`
- `bus_rsp_valid_i` in 1: return beat valid; beats arrive in address order, no backpressure
- `bus_rsp_data_i` in BEAT_W: return beat data

## Operation
- FSM states: IDLE, REQ, RECV, RESP. Reset → IDLE.
- IDLE: `icache_rsp_o.ready = icache_req_i.valid & ~flush_i` (combinational). On accept, latch `addr` with low `log2(LINE_W/8)` bits zeroed, latch `is_prefetch`, clear `killed`, → REQ. A flush in IDLE blocks acceptance that cycle.
- REQ: `bus_req_valid_o=1`, address held stable until `bus_req_ready_i`. On handshake, clear `beat_cnt`, → RECV. Once raised, `bus_req_valid_o` is never withdrawn, even on flush.
- RECV: each `bus_rsp_valid_i` writes `bus_rsp_data_i` into line slice `[beat_cnt*BEAT_W +: BEAT_W]` (beat 0 at LSBs) and increments `beat_cnt`. The beat with `beat_cnt==BEATS-1` → RESP.
- RESP: `icache_rsp_o.valid = ~killed & ~flush_i` for exactly one cycle, with `data` = assembled line and `is_prefetch` = latched flag. Then → IDLE, with no new accept in the RESP cycle.
- Flush in REQ or RECV sets `killed`. The FSM still completes the bus handshake and absorbs all `BEATS` beats, but suppresses the RESP `valid`.
- `bus_rsp_valid_i` outside RECV is a protocol violation; the block ignores it, and verification asserts its absence.
- `icache_rsp_o.data` holds the last assembled line when `valid=0`. The icache must sample it only on `valid`.

## Timing
- Reset values:
  - `icache_rsp_o.ready/valid/is_prefetch` = 0
  - `icache_rsp_o.data` = 0
  - `bus_req_valid_o` = 0
  - `bus_req_addr_o` = 0
  - `beat_cnt` = 0
  - `killed` = 0
- Reset mid-refill returns the FSM to IDLE immediately. The bus-side recovery is the system's responsibility.
- Zero-wait bus timeline:
  - Accept at cycle 0, `bus_req_valid_o` at 1.
  - Beats at 2..BEATS+1.
  - `valid` at BEATS+2, giving minimum latency BEATS+2.
  - Next accept no earlier than BEATS+3.
- Bus stalls add one cycle each; a gap between beats adds one cycle each.
- Throughput: one outstanding line.

## Structure
- Add `icache_refill_state_e` (IDLE/REQ/RECV/RESP) and the `ICACHE_REFILL_BEAT_WIDTH` default (64) to `global_config_pkg`, next to the icache/mem structs.
- No sub-module: FSM, beat counter (`$clog2(BEATS)` bits) and line register live in one module.

## Test plan
Config for all tests: LINE_W=256, BEAT_W=64, ADDR_W=32 (4 beats).
- Demand refill:
  - Stimulus: req addr 0x8000_0014, prefetch=0, zero-wait bus, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - Response: `bus_req_addr_o`=0x8000_0000, `len`=3, `valid` at cycle 6, `data`=0x44..44_33..33_22..22_11..11, `is_prefetch`=0.
- Bus stall with prefetch:
  - Stimulus: `bus_req_ready_i` low for 3 cycles, prefetch=1.
  - Response: address stable throughout the stall, `valid` at cycle 9, `is_prefetch`=1.
- Busy-period request:
  - Stimulus: second request held valid during the refill.
  - Response: `ready`=0 until IDLE; accepted at the first cycle after RESP.
- Flush mid-RECV:
  - Stimulus: flush after beat 1.
  - Response: remaining 2 beats absorbed, no `valid`; next request accepted normally and returns correct data.
- Flush in REQ and in IDLE:
  - Stimulus: flush with `bus_req_ready_i` low; then flush in IDLE.
  - Response (REQ): `bus_req_valid_o` stays high until handshake, no `valid`.
  - Response (IDLE): a concurrent request is not accepted that cycle.
- Async reset:
  - Stimulus: `rst_ni` low during RECV.
  - Response: all outputs zero, state IDLE in the same cycle, no `valid` after release.

Source files
------------

// File: rtl/icache_refill_unit_pkg.sv
// ----------------------------------------------------------------------------
// icache_refill_unit_pkg
// Shared configuration, request/response structs and FSM state type for the
// instruction cache refill engine.
//   ICACHE_LINE_WIDTH / LINE_W : refill line width in bits
//   PLEN / ADDR_W              : physical address width
//   ICACHE_REFILL_BEAT_WIDTH   : memory bus beat width
//   icache2mem_req_t           : line request from the icache miss path
//   mem2icache_rsp_t           : accept / line-delivery response to the icache
//   icache_refill_state_e      : refill FSM states
// ----------------------------------------------------------------------------
package icache_refill_unit_pkg;

  localparam int ICACHE_LINE_WIDTH        = 256;
  localparam int PLEN                     = 32;
  localparam int ICACHE_REFILL_BEAT_WIDTH = 64;

  localparam int LINE_W      = ICACHE_LINE_WIDTH;
  localparam int ADDR_W      = PLEN;
  localparam int BEAT_W      = ICACHE_REFILL_BEAT_WIDTH;
  localparam int BEATS       = LINE_W / BEAT_W;
  localparam int CNT_W       = $clog2(BEATS);
  localparam int LINE_OFFS_W = $clog2(LINE_W / 8);

  localparam logic [ADDR_W-1:0] LINE_OFFS_MASK = ADDR_W'((1 << LINE_OFFS_W) - 1);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic              is_prefetch;
  } icache2mem_req_t;

  typedef struct packed {
    logic              ready;
    logic              valid;
    logic [LINE_W-1:0] data;
    logic              is_prefetch;
  } mem2icache_rsp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RECV = 2'd2,
    RESP = 2'd3
  } icache_refill_state_e;

  // Burst start address: byte offset within the line cleared.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return addr & ~LINE_OFFS_MASK;
  endfunction

endpackage

// File: rtl/icache_refill_unit_if.sv
// ----------------------------------------------------------------------------
// icache_refill_unit_if
// Groups the icache-side request/response and the memory-bus read channel of
// the refill engine.
//   icache_req_i     : line request (valid, addr, is_prefetch)
//   icache_rsp_o     : ready (accept), valid (line delivered), data, is_prefetch
//   flush_i          : cancel outstanding refill
//   bus_req_valid_o  / bus_req_ready_i : burst read request handshake
//   bus_req_addr_o   : line-aligned burst start address
//   bus_req_len_o    : burst length minus one
//   bus_rsp_valid_i  / bus_rsp_data_i  : return beats, no backpressure
// Modport slave is the refill engine, master is the icache/bus side.
// ----------------------------------------------------------------------------
interface icache_refill_unit_if;
  import icache_refill_unit_pkg::*;

  icache2mem_req_t     icache_req_i;
  mem2icache_rsp_t     icache_rsp_o;
  logic                flush_i;
  logic                bus_req_valid_o;
  logic                bus_req_ready_i;
  logic [ADDR_W-1:0]   bus_req_addr_o;
  logic [7:0]          bus_req_len_o;
  logic                bus_rsp_valid_i;
  logic [BEAT_W-1:0]   bus_rsp_data_i;

  modport slave (
    input  icache_req_i, flush_i, bus_req_ready_i, bus_rsp_valid_i, bus_rsp_data_i,
    output icache_rsp_o, bus_req_valid_o, bus_req_addr_o, bus_req_len_o
  );

  modport master (
    output icache_req_i, flush_i, bus_req_ready_i, bus_rsp_valid_i, bus_rsp_data_i,
    input  icache_rsp_o, bus_req_valid_o, bus_req_addr_o, bus_req_len_o
  );

endinterface

// File: rtl/icache_refill_unit.sv
// ----------------------------------------------------------------------------
// icache_refill_unit
// Accepts one icache line request at a time, issues a single burst read,
// assembles the return beats into a full line and hands it back as a
// one-cycle response pulse. A flush cancels the delivery but never the bus
// transaction: the request handshake is completed and all beats are absorbed.
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset
//   refill_if  : icache request/response and memory bus (slave modport)
//
// state | meaning
// IDLE  | waiting for an icache request; ready follows valid & ~flush
// REQ   | burst request presented, held until bus_req_ready_i
// RECV  | collecting beats, beat 0 into the line LSBs
// RESP  | one-cycle line delivery, suppressed if killed or flushing
// ----------------------------------------------------------------------------
module icache_refill_unit
  import icache_refill_unit_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  icache_refill_unit_if.slave refill_if
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [7:0]       BURST_LEN = 8'(BEATS - 1);

  icache_refill_state_e r_state;
  icache_refill_state_e w_state_next;

  logic [ADDR_W-1:0] r_addr;
  logic              r_pref;
  logic              r_killed;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic [LINE_W-1:0] r_line;

  logic w_accept;
  logic w_req_hs;
  logic w_beat;
  logic w_rsp_valid;
  logic w_bus_req_valid;
  logic w_kill;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_accept        = 1'b0;
    w_req_hs        = 1'b0;
    w_beat          = 1'b0;
    w_rsp_valid     = 1'b0;
    w_bus_req_valid = 1'b0;
    w_kill          = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept = refill_if.icache_req_i.valid & ~refill_if.flush_i;
        if (w_accept) begin
          w_state_next = REQ;
        end
      end
      REQ: begin
        // Valid stays up until the handshake even when flushed.
        w_bus_req_valid = 1'b1;
        w_req_hs        = refill_if.bus_req_ready_i;
        w_kill          = refill_if.flush_i;
        if (w_req_hs) begin
          w_state_next = RECV;
        end
      end
      RECV: begin
        w_beat = refill_if.bus_rsp_valid_i;
        w_kill = refill_if.flush_i;
        if (w_beat && (r_beat_cnt == LAST_BEAT)) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        w_rsp_valid  = ~r_killed & ~refill_if.flush_i;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr     <= '0;
      r_pref     <= 1'b0;
      r_killed   <= 1'b0;
      r_beat_cnt <= '0;
      r_line     <= '0;
    end else begin
      if (w_accept) begin
        r_addr   <= line_align(refill_if.icache_req_i.addr);
        r_pref   <= refill_if.icache_req_i.is_prefetch;
        r_killed <= 1'b0;
      end
      if (w_kill) begin
        r_killed <= 1'b1;
      end
      if (w_req_hs) begin
        r_beat_cnt <= '0;
      end
      if (w_beat) begin
        for (int b = 0; b < BEATS; b++) begin
          if (r_beat_cnt == CNT_W'(b)) begin
            r_line[b*BEAT_W +: BEAT_W] <= refill_if.bus_rsp_data_i;
          end
        end
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end
    end
  end

  // Data and is_prefetch hold their last values; only valid qualifies them.
  assign refill_if.icache_rsp_o = '{ready:       w_accept,
                                    valid:       w_rsp_valid,
                                    data:        r_line,
                                    is_prefetch: r_pref};

  assign refill_if.bus_req_valid_o = w_bus_req_valid;
  assign refill_if.bus_req_addr_o  = r_addr;
  assign refill_if.bus_req_len_o   = BURST_LEN;

endmodule

// File: tb/tb_icache_refill_unit.sv
// ----------------------------------------------------------------------------
// tb_icache_refill_unit
// Directed bench for icache_refill_unit: a table of refill vectors with
// hand-computed line addresses, assembled lines and latencies, plus
// hand-written sequences for busy-period requests, flushes and async reset.
// Inputs change 1 time unit after the rising edge, outputs are sampled on
// the falling edge.
// ----------------------------------------------------------------------------
module tb_icache_refill_unit;
  import icache_refill_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  icache_refill_unit_if rif();

  icache_refill_unit dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .refill_if (rif.slave)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              pref;
    int                stall;
    logic [BEAT_W-1:0] beats[BEATS];
    logic [ADDR_W-1:0] exp_addr;
    logic [LINE_W-1:0] exp_data;
    int                exp_lat;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [ADDR_W-1:0] addr, input logic pref, input string name, output int acc);
    rif.icache_req_i = '{valid: 1'b1, addr: addr, is_prefetch: pref};
    @(negedge clk);
    chk({name, "_accept_ready"}, LINE_W'(rif.icache_rsp_o.ready), 1);
    acc = cyc;
    tick();
    rif.icache_req_i.valid = 1'b0;
  endtask

  // Starts in the first REQ cycle, ends one cycle after the response pulse.
  task automatic finish_refill(input logic [BEAT_W-1:0] beats[BEATS], input int stall,
                               input logic [ADDR_W-1:0] exp_addr, input logic [LINE_W-1:0] exp_data,
                               input logic exp_pref, input int acc, input int exp_lat, input string name);
    int n;
    for (int c = 0; c <= stall; c++) begin
      rif.bus_req_ready_i = (c == stall);
      @(negedge clk);
      chk({name, "_bus_req_valid"}, LINE_W'(rif.bus_req_valid_o), 1);
      chk({name, "_bus_req_addr"}, LINE_W'(rif.bus_req_addr_o), LINE_W'(exp_addr));
      chk({name, "_bus_req_len"}, LINE_W'(rif.bus_req_len_o), 3);
      chk({name, "_req_busy_ready"}, LINE_W'(rif.icache_rsp_o.ready), 0);
      tick();
    end
    rif.bus_req_ready_i = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      rif.bus_rsp_valid_i = 1'b1;
      rif.bus_rsp_data_i  = beats[b];
      @(negedge clk);
      chk({name, "_recv_bus_req_valid"}, LINE_W'(rif.bus_req_valid_o), 0);
      chk({name, "_early_valid"}, LINE_W'(rif.icache_rsp_o.valid), 0);
      chk({name, "_recv_busy_ready"}, LINE_W'(rif.icache_rsp_o.ready), 0);
      tick();
    end
    rif.bus_rsp_valid_i = 1'b0;
    rif.bus_rsp_data_i  = '0;
    n = 0;
    @(negedge clk);
    while (rif.icache_rsp_o.valid !== 1'b1 && n < 8) begin
      tick();
      @(negedge clk);
      n++;
    end
    chk({name, "_rsp_valid"}, LINE_W'(rif.icache_rsp_o.valid), 1);
    chk({name, "_latency"}, LINE_W'(cyc - acc), LINE_W'(exp_lat));
    chk({name, "_rsp_data"}, rif.icache_rsp_o.data, exp_data);
    chk({name, "_rsp_pref"}, LINE_W'(rif.icache_rsp_o.is_prefetch), LINE_W'(exp_pref));
    chk({name, "_resp_ready"}, LINE_W'(rif.icache_rsp_o.ready), 0);
    tick();
  endtask

  task automatic post_pulse(input logic [LINE_W-1:0] exp_data, input string name);
    @(negedge clk);
    chk({name, "_pulse_end"}, LINE_W'(rif.icache_rsp_o.valid), 0);
    chk({name, "_data_hold"}, rif.icache_rsp_o.data, exp_data);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;

    vecs[0].addr = 32'h8000_0014; vecs[0].pref = 1'b0; vecs[0].stall = 0;
    vecs[0].beats = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                      64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    vecs[0].exp_addr = 32'h8000_0000; vecs[0].exp_lat = 6;
    vecs[0].exp_data = 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;

    vecs[1].addr = 32'h1234_567F; vecs[1].pref = 1'b1; vecs[1].stall = 3;
    vecs[1].beats = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                      64'hDEAD_BEEF_CAFE_F00D, 64'h0000_0000_0000_0001};
    vecs[1].exp_addr = 32'h1234_5660; vecs[1].exp_lat = 9;
    vecs[1].exp_data = 256'h0000000000000001_DEADBEEFCAFEF00D_FEDCBA9876543210_0123456789ABCDEF;

    vecs[2].addr = 32'hFFFF_FFE0; vecs[2].pref = 1'b0; vecs[2].stall = 1;
    vecs[2].beats = '{64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A,
                      64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000};
    vecs[2].exp_addr = 32'hFFFF_FFE0; vecs[2].exp_lat = 7;
    vecs[2].exp_data = 256'h0000000000000000_FFFFFFFFFFFFFFFF_5A5A5A5A5A5A5A5A_A5A5A5A5A5A5A5A5;

    vecs[3].addr = 32'h0000_003F; vecs[3].pref = 1'b1; vecs[3].stall = 0;
    vecs[3].beats = '{64'h1, 64'h2, 64'h3, 64'h4};
    vecs[3].exp_addr = 32'h0000_0020; vecs[3].exp_lat = 6;
    vecs[3].exp_data = 256'h0000000000000004_0000000000000003_0000000000000002_0000000000000001;

    rif.icache_req_i    = '{valid: 1'b0, addr: '0, is_prefetch: 1'b0};
    rif.flush_i         = 1'b0;
    rif.bus_req_ready_i = 1'b0;
    rif.bus_rsp_valid_i = 1'b0;
    rif.bus_rsp_data_i  = '0;
    rst_n = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", LINE_W'(rif.icache_rsp_o.ready), 0);
    chk("rst_valid", LINE_W'(rif.icache_rsp_o.valid), 0);
    chk("rst_pref", LINE_W'(rif.icache_rsp_o.is_prefetch), 0);
    chk("rst_data", rif.icache_rsp_o.data, 0);
    chk("rst_bus_req_valid", LINE_W'(rif.bus_req_valid_o), 0);
    chk("rst_bus_req_addr", LINE_W'(rif.bus_req_addr_o), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Table-driven refills
    for (int i = 0; i < 4; i++) begin
      accept(vecs[i].addr, vecs[i].pref, $sformatf("vec%0d", i), acc);
      finish_refill(vecs[i].beats, vecs[i].stall, vecs[i].exp_addr, vecs[i].exp_data,
                    vecs[i].pref, acc, vecs[i].exp_lat, $sformatf("vec%0d", i));
      post_pulse(vecs[i].exp_data, $sformatf("vec%0d", i));
    end

    // Second request held valid during a refill
    accept(32'h0000_6010, 1'b0, "busy", acc);
    rif.icache_req_i = '{valid: 1'b1, addr: 32'h0000_7000, is_prefetch: 1'b1};
    finish_refill(vecs[0].beats, 0, 32'h0000_6000, vecs[0].exp_data, 1'b0, acc, 6, "busy");
    accept(32'h0000_7000, 1'b1, "busy_next", acc);
    finish_refill(vecs[3].beats, 0, 32'h0000_7000, vecs[3].exp_data, 1'b1, acc, 6, "busy_next");
    post_pulse(vecs[3].exp_data, "busy_next");

    // Flush after beat 1: beats 2 and 3 absorbed, no delivery
    accept(32'h0000_1000, 1'b0, "frecv", acc);
    rif.bus_req_ready_i = 1'b1;
    tick();
    rif.bus_req_ready_i = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      rif.bus_rsp_valid_i = 1'b1;
      rif.bus_rsp_data_i  = vecs[2].beats[b];
      rif.flush_i         = (b == 2);
      @(negedge clk);
      chk("frecv_no_valid", LINE_W'(rif.icache_rsp_o.valid), 0);
      tick();
    end
    rif.bus_rsp_valid_i = 1'b0;
    rif.flush_i         = 1'b0;
    rif.icache_req_i    = '{valid: 1'b1, addr: 32'h0000_2048, is_prefetch: 1'b1};
    @(negedge clk);
    chk("frecv_killed_valid", LINE_W'(rif.icache_rsp_o.valid), 0);
    chk("frecv_resp_ready", LINE_W'(rif.icache_rsp_o.ready), 0);
    tick();
    accept(32'h0000_2048, 1'b1, "frecv_next", acc);
    finish_refill(vecs[1].beats, 0, 32'h0000_2040, vecs[1].exp_data, 1'b1, acc, 6, "frecv_next");
    post_pulse(vecs[1].exp_data, "frecv_next");

    // Flush while the burst request is stalled
    accept(32'h0000_3000, 1'b1, "freq", acc);
    rif.flush_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      rif.bus_req_ready_i = (c == 3);
      @(negedge clk);
      chk("freq_bus_req_valid", LINE_W'(rif.bus_req_valid_o), 1);
      chk("freq_bus_req_addr", LINE_W'(rif.bus_req_addr_o), 32'h0000_3000);
      tick();
      rif.flush_i = 1'b0;
    end
    rif.bus_req_ready_i = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      rif.bus_rsp_valid_i = 1'b1;
      rif.bus_rsp_data_i  = vecs[0].beats[b];
      @(negedge clk);
      chk("freq_no_valid", LINE_W'(rif.icache_rsp_o.valid), 0);
      tick();
    end
    rif.bus_rsp_valid_i = 1'b0;
    @(negedge clk);
    chk("freq_killed_valid", LINE_W'(rif.icache_rsp_o.valid), 0);
    tick();

    // Flush in IDLE blocks a concurrent request for that cycle only
    rif.icache_req_i = '{valid: 1'b1, addr: 32'h0000_4000, is_prefetch: 1'b0};
    rif.flush_i      = 1'b1;
    @(negedge clk);
    chk("fidle_ready", LINE_W'(rif.icache_rsp_o.ready), 0);
    tick();
    rif.flush_i = 1'b0;
    accept(32'h0000_4000, 1'b0, "fidle_next", acc);
    finish_refill(vecs[2].beats, 0, 32'h0000_4000, vecs[2].exp_data, 1'b0, acc, 6, "fidle_next");
    post_pulse(vecs[2].exp_data, "fidle_next");

    // Async reset during RECV
    accept(32'h0000_5000, 1'b1, "arst", acc);
    rif.bus_req_ready_i = 1'b1;
    tick();
    rif.bus_req_ready_i = 1'b0;
    rif.bus_rsp_valid_i = 1'b1;
    rif.bus_rsp_data_i  = vecs[1].beats[0];
    tick();
    rif.bus_rsp_data_i  = vecs[1].beats[1];
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", LINE_W'(rif.icache_rsp_o.valid), 0);
    chk("arst_ready", LINE_W'(rif.icache_rsp_o.ready), 0);
    chk("arst_pref", LINE_W'(rif.icache_rsp_o.is_prefetch), 0);
    chk("arst_data", rif.icache_rsp_o.data, 0);
    chk("arst_bus_req_valid", LINE_W'(rif.bus_req_valid_o), 0);
    chk("arst_bus_req_addr", LINE_W'(rif.bus_req_addr_o), 0);
    rif.bus_rsp_valid_i = 1'b0;
    rif.bus_rsp_data_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("arst_no_valid", LINE_W'(rif.icache_rsp_o.valid), 0);
      tick();
    end
    accept(32'h0000_5008, 1'b0, "arst_next", acc);
    finish_refill(vecs[0].beats, 0, 32'h0000_5000, vecs[0].exp_data, 1'b0, acc, 6, "arst_next");
    post_pulse(vecs[0].exp_data, "arst_next");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
